// File: rtl/vca.sv
// Voltage-controlled amplifier: 3-stage pipeline scaling a signed 12-bit sample by a saturated envelope+level gain.
// Optional envelope slew limiter enabled by defining VCA_SMOOTH_EN.
module vca (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [11:0] sample_in,
    input  logic               sample_valid_in,
    input  logic        [9:0]  envelope,
    input  logic        [9:0]  level,
    output logic signed [11:0] sample_out,
    output logic               sample_valid_out
);

    localparam int STAGES = 3;

    logic [STAGES:1]    vld_pipe;
    logic [9:0]         env_used;
    logic [10:0]        gain_sum;
    logic [9:0]         gain;
    logic [10:0]        gain_eff;

    logic signed [11:0] s1_sample;
    logic [10:0]        s1_gain;
    logic signed [22:0] prod;
    logic signed [22:0] s2_prod;
    logic signed [22:0] shifted;

`ifdef VCA_SMOOTH_EN
    logic [9:0] env_s;
    logic [9:0] env_nxt;
    logic [9:0] dist;
    logic [9:0] step;

    // Slew env_s toward envelope by at most 8 per accepted sample.
    always_comb begin
        dist    = (envelope >= env_s) ? (envelope - env_s) : (env_s - envelope);
        step    = (dist > 10'd8) ? 10'd8 : dist;
        env_nxt = (envelope >= env_s) ? (env_s + step) : (env_s - step);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            env_s <= '0;
        else if (sample_valid_in)
            env_s <= env_nxt;
    end

    assign env_used = env_nxt;
`else
    assign env_used = envelope;
`endif

    // Full-scale gain becomes exactly 1024 so that gain 1023 is true unity.
    always_comb begin
        gain_sum = {1'b0, env_used} + {1'b0, level};
        gain     = gain_sum[10] ? 10'd1023 : gain_sum[9:0];
        gain_eff = (gain == 10'd1023) ? 11'd1024 : {1'b0, gain};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:1], sample_valid_in};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_sample <= '0;
            s1_gain   <= '0;
        end else if (sample_valid_in) begin
            s1_sample <= sample_in;
            s1_gain   <= gain_eff;
        end
    end

    // Gain is zero-extended to keep it non-negative in the signed multiply.
    assign prod = 23'(s1_sample) * 23'($signed({1'b0, s1_gain}));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            s2_prod <= '0;
        else if (vld_pipe[1])
            s2_prod <= prod;
    end

    // |product| <= 2^21, so the shifted result always fits in 12 bits.
    assign shifted = s2_prod >>> 10;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sample_out <= '0;
        else if (vld_pipe[2])
            sample_out <= shifted[11:0];
    end

    assign sample_valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_vca.sv
// Scoreboard bench for vca: expected outputs queued at drive time, popped on sample_valid_out.
module tb_vca;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [11:0] sample_in = '0;
    logic               sample_valid_in = 1'b0;
    logic        [9:0]  envelope = '0;
    logic        [9:0]  level = '0;
    logic signed [11:0] sample_out;
    logic               sample_valid_out;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    int   failed = 0;
    int   cyc = 0;
    logic signed [31:0] last_out = 0;
`ifdef VCA_SMOOTH_EN
    int   m_env = 0;
`endif

    vca dut (
        .clk              (clk),
        .reset            (reset),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .envelope         (envelope),
        .level            (level),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(int s, int env, int lvl);
        int eu, g, p;
`ifdef VCA_SMOOTH_EN
        if (env >= m_env) m_env += (env - m_env > 8) ? 8 : env - m_env;
        else              m_env -= (m_env - env > 8) ? 8 : m_env - env;
        eu = m_env;
`else
        eu = env;
`endif
        g = eu + lvl;
        if (g > 1023) g = 1023;
        if (g == 1023) g = 1024;
        p = s * g;
        return (p >= 0) ? p / 1024 : -((-p + 1023) / 1024);
    endfunction

    task automatic send(int s, int env, int lvl);
        @(negedge clk);
        sample_in       = 12'(s);
        envelope        = 10'(env);
        level           = 10'(lvl);
        sample_valid_in = 1'b1;
        q.push_back('{model(s, env, lvl), cyc + 3});
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            sample_valid_in = 1'b0;
            sample_in       = 12'($urandom);
            envelope        = 10'($urandom);
            level           = 10'($urandom);
        end
    endtask

    // Output monitor, sampled 1 time unit after the rising edge.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (!reset) begin
            last_out = 0;
        end else if (sample_valid_out) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sample_out", sample_out, e.val);
                chk("latency", cyc, e.due);
                last_out = e.val;
            end
        end else begin
            chk("hold", sample_out, last_out);
        end
    end

    initial begin
        // Reset held with toggling inputs
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            sample_valid_in = 1'($urandom);
            sample_in       = 12'($urandom);
            envelope        = 10'($urandom);
            level           = 10'($urandom);
            chk("rst_sample_out", sample_out, 0);
            chk("rst_valid_out", {31'b0, sample_valid_out}, 0);
        end

        // Sample accepted on the first edge after release: unity gain
        @(negedge clk);
        reset           = 1'b1;
        sample_in       = 12'sd1000;
        envelope        = 10'd1023;
        level           = 10'd0;
        sample_valid_in = 1'b1;
        q.push_back('{model(1000, 1023, 0), cyc + 3});
        idle(6);
        chk("drain_first", q.size(), 0);

        // Half gain, negative full scale; saturation; tiny gain with floor
        send(-2048, 512, 0);
        idle(5);
        send(700, 800, 400);
        send(1, 1, 0);
        send(-1, 1, 0);
        send(1024, 300, 200);
        send(-1537, 0, 777);
        send(2047, 0, 0);
        idle(6);
        chk("drain_basic", q.size(), 0);

        // Back-to-back samples
        send(100, 1023, 0);
        send(-200, 1023, 0);
        send(300, 1023, 0);
        idle(6);
        chk("drain_b2b", q.size(), 0);

        // Reset one cycle after the second sample discards all three
        send(100, 1023, 0);
        send(-200, 1023, 0);
        @(negedge clk);
        reset           = 1'b0;
        sample_in       = 12'sd300;
        sample_valid_in = 1'b1;
        q.delete();
`ifdef VCA_SMOOTH_EN
        m_env = 0;
`endif
        @(negedge clk);
        chk("rst_mid_out", sample_out, 0);
        reset           = 1'b1;
        sample_valid_in = 1'b0;
        idle(6);
        chk("drain_rst_mid", q.size(), 0);

        // Envelope step to full scale after reset
        repeat (130) send(1000, 1023, 0);
        idle(6);
        chk("drain_step", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
